pxs_sync_gen: RTL and testbench

PXS_SYNC_GEN -- requirements
Module: pxs_sync_gen

---
 rtl/pxs_sync_gen.sv | 79 +++++++
 tb/tb_pxs_sync_gen.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/pxs_sync_gen.sv
// VGA-style pixel stream generator: free-running h/v counters drive a registered
// 26-bit stream {HS, VS, XC, YC, Active, RGB} plus an end-of-frame pulse.
module pxs_sync_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter logic [2:0] BACKGROUND = 3'b101,
    parameter int PATTERN   = 0
) (
    input  logic        px_clk,
    input  logic        px_rst_n,
    output logic [25:0] RGBStr_o,
    output logic        endframe_o
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
    localparam logic [9:0] H_VIS_LAST = 10'(H_VISIBLE - 1);
    localparam logic [9:0] V_VIS_LAST = 10'(V_VISIBLE - 1);
    localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    // Idle stream: syncs deasserted (high), everything else zero.
    localparam logic [25:0] STREAM_IDLE = {1'b1, 1'b1, 24'd0};

    logic [9:0] hcnt;
    logic [9:0] vcnt;

    logic       h_wrap;
    logic       v_wrap;
    logic       active_c;
    logic       hs_c;
    logic       vs_c;
    logic [2:0] rgb_c;
    logic       endframe_c;

    always_comb begin
        h_wrap     = (hcnt == H_LAST);
        v_wrap     = (vcnt == V_LAST);
        active_c   = (hcnt < H_VIS) && (vcnt < V_VIS);
        hs_c       = !((hcnt >= HS_START) && (hcnt < HS_END));
        vs_c       = !((vcnt >= VS_START) && (vcnt < VS_END));
        endframe_c = (hcnt == H_VIS_LAST) && (vcnt == V_VIS_LAST);
        rgb_c      = 3'b000;
        if (active_c) begin
            // Bar index is the top three bits of x: 128-pixel wide bars.
            rgb_c = (PATTERN == 1) ? hcnt[9:7] : BACKGROUND;
        end
    end

    always_ff @(posedge px_clk or negedge px_rst_n) begin
        if (!px_rst_n) begin
            hcnt       <= 10'd0;
            vcnt       <= 10'd0;
            RGBStr_o   <= STREAM_IDLE;
            endframe_o <= 1'b0;
        end else begin
            hcnt <= h_wrap ? 10'd0 : hcnt + 10'd1;
            if (h_wrap) begin
                vcnt <= v_wrap ? 10'd0 : vcnt + 10'd1;
            end
            RGBStr_o   <= {hs_c, vs_c, hcnt, vcnt, active_c, rgb_c};
            endframe_o <= endframe_c;
        end
    end

endmodule

// File: tb/tb_pxs_sync_gen.sv
// Bench for pxs_sync_gen: default timing (solid and bars) plus a tiny-timing
// instance so whole frames fit in a short run.
module tb_pxs_sync_gen;

    logic        clk;
    logic        rst_n;
    logic [25:0] s0, s1, s2;
    logic        ef0, ef1, ef2;

    int tests = 0;
    int fails = 0;
    int k;
    logic cmp_en = 1'b0;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // k = number of rising edges since reset release
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) k <= 0;
        else        k <= k + 1;
    end

    pxs_sync_gen #(.PATTERN(0)) dut0 (
        .px_clk(clk), .px_rst_n(rst_n), .RGBStr_o(s0), .endframe_o(ef0));

    pxs_sync_gen #(.PATTERN(1)) dut1 (
        .px_clk(clk), .px_rst_n(rst_n), .RGBStr_o(s1), .endframe_o(ef1));

    pxs_sync_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .BACKGROUND(3'b011), .PATTERN(0)
    ) dut2 (
        .px_clk(clk), .px_rst_n(rst_n), .RGBStr_o(s2), .endframe_o(ef2));

    // ---------------- model ----------------
    // Returns {endframe, HS, VS, XC, YC, Active, RGB} for the k-th edge after release.
    function automatic logic [26:0] model(int kk, int hv, int hf, int hsw, int hb,
                                          int vv, int vf, int vsw, int vb,
                                          logic [2:0] bg, int pat);
        int n, ht, vt, x, y;
        logic act, hs, vs, ef;
        logic [2:0] rgb;
        if (kk == 0) return {1'b0, 1'b1, 1'b1, 24'd0};
        n   = kk - 1;
        ht  = hv + hf + hsw + hb;
        vt  = vv + vf + vsw + vb;
        x   = n % ht;
        y   = (n / ht) % vt;
        act = (x < hv) && (y < vv);
        hs  = !((x >= hv + hf) && (x < hv + hf + hsw));
        vs  = !((y >= vv + vf) && (y < vv + vf + vsw));
        rgb = act ? (pat == 1 ? 3'(x / 128) : bg) : 3'b000;
        ef  = (x == hv - 1) && (y == vv - 1);
        return {ef, hs, vs, 10'(x), 10'(y), act, rgb};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 40)
                $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard: every cycle ----------------
    always @(negedge clk) begin
        if (cmp_en) begin
            check("dut0_cycle", {5'd0, ef0, s0}, {5'd0, model(k, 640, 16, 96, 48, 480, 10, 2, 33, 3'b101, 0)});
            check("dut1_cycle", {5'd0, ef1, s1}, {5'd0, model(k, 640, 16, 96, 48, 480, 10, 2, 33, 3'b101, 1)});
            check("dut2_cycle", {5'd0, ef2, s2}, {5'd0, model(k, 8, 2, 3, 2, 4, 1, 2, 1, 3'b011, 0)});
        end
    end

    function automatic logic [9:0] xc(input logic [25:0] s); return s[23:14]; endfunction
    function automatic logic [9:0] yc(input logic [25:0] s); return s[13:4];  endfunction

    // ---------------- directed sequence ----------------
    int hs_low, hs_first, act_low, cyc, last_ef, vs_low, n_ef, bound;
    logic line_wrap, after_ef, frame_wrap;

    initial begin
        rst_n = 1'b0;
        cmp_en = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_stream", 32'(s0), 32'h3000000);
        check("reset_endframe", 32'(ef0), 32'd0);

        rst_n = 1'b1;
        @(negedge clk);
        check("first_px_solid", 32'(s0), {6'd0, 1'b1, 1'b1, 10'd0, 10'd0, 1'b1, 3'b101});
        check("first_px_bars", 32'(s1), {6'd0, 1'b1, 1'b1, 10'd0, 10'd0, 1'b1, 3'b000});
        check("first_px_small", 32'(s2), {6'd0, 1'b1, 1'b1, 10'd0, 10'd0, 1'b1, 3'b011});

        hs_low = 0; hs_first = -1; act_low = 0; last_ef = -1; vs_low = 0; n_ef = 0;
        line_wrap = 0; after_ef = 0; frame_wrap = 0;
        for (cyc = 0; cyc < 1700; cyc++) begin
            if (cyc > 0) @(negedge clk);
            // default timing, first line
            if (yc(s0) == 10'd0) begin
                if (!s0[25]) begin
                    if (hs_first < 0) hs_first = int'(xc(s0));
                    hs_low++;
                end
                if (!s0[3]) act_low++;
            end
            if (line_wrap) begin
                check("line_wrap_xc", 32'(xc(s0)), 32'd0);
                check("line_wrap_yc", 32'(yc(s0)), 32'd1);
            end
            line_wrap = (xc(s0) == 10'd799) && (yc(s0) == 10'd0);
            // colour bars on the first line
            if (yc(s1) == 10'd0) begin
                case (xc(s1))
                    10'd127: check("bar_x127", 32'(s1[2:0]), 32'd0);
                    10'd128: check("bar_x128", 32'(s1[2:0]), 32'd1);
                    10'd300: check("bar_x300", 32'(s1[2:0]), 32'd2);
                    10'd400: check("bar_x400", 32'(s1[2:0]), 32'd3);
                    10'd512: check("bar_x512", 32'(s1[2:0]), 32'd4);
                    10'd639: check("bar_x639", 32'(s1[2:0]), 32'd4);
                    10'd640: check("bar_x640", 32'(s1[2:0]), 32'd0);
                    default: ;
                endcase
            end
            // tiny timing: whole frames
            if (after_ef) begin
                check("post_ef_pulse", 32'(ef2), 32'd0);
                check("post_ef_xc", 32'(xc(s2)), 32'd8);
                check("post_ef_active", 32'(s2[3]), 32'd0);
                check("post_ef_rgb", 32'(s2[2:0]), 32'd0);
            end
            if (frame_wrap) begin
                check("frame_wrap_xc", 32'(xc(s2)), 32'd0);
                check("frame_wrap_yc", 32'(yc(s2)), 32'd0);
            end
            frame_wrap = (xc(s2) == 10'd14) && (yc(s2) == 10'd7);
            after_ef = ef2;
            if (!s2[24]) vs_low++;
            if (ef2) begin
                check("ef_xc", 32'(xc(s2)), 32'd7);
                check("ef_yc", 32'(yc(s2)), 32'd3);
                if (last_ef >= 0) begin
                    check("ef_period", 32'(cyc - last_ef), 32'd120);
                    check("vs_low_per_frame", 32'(vs_low), 32'd30);
                end
                last_ef = cyc;
                vs_low = 0;
                n_ef++;
            end
        end
        check("hs_low_count", 32'(hs_low), 32'd96);
        check("hs_first_xc", 32'(hs_first), 32'd656);
        check("inactive_count", 32'(act_low), 32'd160);
        check("ef_seen", 32'(n_ef >= 10), 32'd1);

        // mid-frame asynchronous reset at XC=300 on line 2
        bound = 0;
        while (!(xc(s0) == 10'd300 && yc(s0) == 10'd2) && bound < 3000) begin
            @(negedge clk);
            bound++;
        end
        check("reach_x300", 32'(bound < 3000), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_dut0", 32'(s0), 32'h3000000);
        check("async_rst_dut2", 32'(s2), 32'h3000000);
        check("async_rst_ef", 32'(ef0), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("restart_dut0", 32'(s0), {6'd0, 1'b1, 1'b1, 10'd0, 10'd0, 1'b1, 3'b101});
        check("restart_dut2", 32'(s2), {6'd0, 1'b1, 1'b1, 10'd0, 10'd0, 1'b1, 3'b011});
        repeat (300) @(negedge clk);
        check("restart_pos", 32'(xc(s0)), 32'd300);

        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
